// File: rtl/pc_sequencer_fsm.sv
// rtl/pc_sequencer_fsm.sv - fetch/increment/load sequencer for module_PC (optional PC_SEQ_BREAKPOINT_EN)
module pc_sequencer_fsm #(
  parameter int               ANCHO    = 4,
  parameter logic [ANCHO-1:0] END_ADDR = {ANCHO{1'b1}},
  parameter int               TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             mem_ready_i,
  input  logic             jump_req_i,
  input  logic [ANCHO-1:0] jump_addr_i,
  input  logic [ANCHO-1:0] pc_cur_i,
`ifdef PC_SEQ_BREAKPOINT_EN
  input  logic             bp_en_i,
  input  logic [ANCHO-1:0] bp_addr_i,
  output logic             bp_hit_o,
`endif
  output logic [1:0]       pc_op_o,
  output logic [ANCHO-1:0] pc_load_o,
  output logic             fetch_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT    = 3'd3,
    S_ADVANCE = 3'd4,
    S_JUMP    = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_HOLD  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [7:0]       cnt;
  logic [ANCHO-1:0] pc_load;
  logic             done;
  logic             err;
  logic             halt_pend;

  // control strobes produced alongside the next-state decision
  logic             start_run;
  logic             resume;
  logic             latch_jump;
  logic             set_done;
  logic             set_err;
  logic             in_flight;

`ifdef PC_SEQ_BREAKPOINT_EN
  logic             bp_hit;
  logic             bp_stop;
  logic             bp_trip;
  logic [ANCHO-1:0] fetch_addr;

  // predict the address the next FETCH would use; the PC update of ADVANCE/JUMP lands on the same edge
  always_comb begin
    fetch_addr = pc_cur_i;
    case (state)
      S_ADVANCE: fetch_addr = pc_cur_i + ANCHO'(1);
      S_JUMP:    fetch_addr = pc_load;
      default:   fetch_addr = pc_cur_i;
    endcase
    // resuming from a breakpoint halt lets that one fetch through
    bp_stop = bp_en_i && (fetch_addr == bp_addr_i) && !(state == S_HALT && bp_hit);
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic and control strobes
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    resume     = 1'b0;
    latch_jump = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
    bp_trip    = 1'b0;
`endif
    case (state)
      S_CLEAR: state_next = S_IDLE;
      S_IDLE: begin
        if (start_i) begin
          state_next = S_FETCH;
          start_run  = 1'b1;
        end
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        if (mem_ready_i) begin
          if (jump_req_i) begin
            latch_jump = 1'b1;
            state_next = S_JUMP;
          end else if (pc_cur_i == END_ADDR) begin
            set_done   = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_ADVANCE;
          end
        end else if (cnt == CNT_LAST) begin
          set_err    = 1'b1;
          state_next = S_HALT;
        end
      end
      S_ADVANCE,
      S_JUMP: state_next = halt_pend ? S_HALT : S_FETCH;
      S_HALT: begin
        if (start_i) begin
          state_next = S_FETCH;
          resume     = 1'b1;
        end
      end
      default: state_next = S_CLEAR;
    endcase
`ifdef PC_SEQ_BREAKPOINT_EN
    if (state_next == S_FETCH && bp_stop) begin
      state_next = S_HALT;
      bp_trip    = 1'b1;
    end
`endif
  end

  assign in_flight = (state == S_FETCH) || (state == S_WAIT) ||
                     (state == S_ADVANCE) || (state == S_JUMP);

  // timeout counter, jump target latch and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pc_load   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      halt_pend <= 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
      bp_hit    <= 1'b0;
`endif
    end else begin
      if (state == S_FETCH) begin
        cnt <= '0;
      end else if (state == S_WAIT && !mem_ready_i) begin
        cnt <= cnt + 8'd1;
      end

      if (latch_jump) begin
        pc_load <= jump_addr_i;
      end

      if (start_run) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else if (set_done) begin
        done <= 1'b1;
      end

      if (resume) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end

      // a halt request waits for the fetch/update pair in flight to finish
      if (start_run || resume) begin
        halt_pend <= 1'b0;
      end else if (in_flight && halt_i) begin
        halt_pend <= 1'b1;
      end

`ifdef PC_SEQ_BREAKPOINT_EN
      if (bp_trip) begin
        bp_hit <= 1'b1;
      end else if (resume) begin
        bp_hit <= 1'b0;
      end
`endif
    end
  end

  // Moore output decode
  always_comb begin
    pc_op_o = OP_HOLD;
    case (state)
      S_CLEAR:   pc_op_o = OP_CLEAR;
      S_ADVANCE: pc_op_o = OP_INC;
      S_JUMP:    pc_op_o = OP_LOAD;
      default:   pc_op_o = OP_HOLD;
    endcase
  end

  assign pc_load_o = pc_load;
  assign fetch_o   = (state == S_FETCH);
  assign busy_o    = in_flight;
  assign done_o    = done;
  assign err_o     = err;
`ifdef PC_SEQ_BREAKPOINT_EN
  assign bp_hit_o  = bp_hit;
`endif

endmodule

// File: tb/tb_pc_sequencer_fsm.sv
// tb/tb_pc_sequencer_fsm.sv - directed bench for pc_sequencer_fsm with a module_PC model
module tb_pc_sequencer_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       halt_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       jump_req_i = 1'b0;
  logic [3:0] jump_addr_i = 4'h0;
  logic [3:0] pc;
  logic [1:0] pc_op_o;
  logic [3:0] pc_load_o;
  logic       fetch_o, busy_o, done_o, err_o;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic       bp_en_i = 1'b0;
  logic [3:0] bp_addr_i = 4'h0;
  logic       bp_hit_o;
`endif

  int total = 0;
  int bad = 0;

  pc_sequencer_fsm #(.ANCHO(4), .END_ADDR(4'hF), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i),
    .mem_ready_i(mem_ready_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .pc_cur_i(pc),
`ifdef PC_SEQ_BREAKPOINT_EN
    .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .bp_hit_o(bp_hit_o),
`endif
    .pc_op_o(pc_op_o), .pc_load_o(pc_load_o), .fetch_o(fetch_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // module_PC model
  always @(posedge clk) begin
    if (rst) pc <= 4'h0;
    else case (pc_op_o)
      2'b00: pc <= 4'h0;
      2'b10: pc <= pc + 4'h1;
      2'b11: pc <= pc_load_o;
      default: pc <= pc;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_wait();
    return busy_o && (pc_op_o == 2'b01) && !fetch_o;
  endfunction

  // run until busy drops, counting increments and fetches
  task automatic run_until_idle(output int adv, output int fetches);
    bit ok;
    adv = 0; fetches = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pc_op_o == 2'b10) adv++;
      if (fetch_o) fetches++;
      if (!busy_o) begin ok = 1; break; end
    end
    check("run_budget", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int adv, fc, wcount;
    bit found;

    // 1: reset and sequential run to END_ADDR
    rst = 1'b1;
    tick(); tick();
    check("rst_pc_op", pc_op_o, 2'b00);
    check("rst_fetch", fetch_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_load", pc_load_o, 4'h0);
    rst = 1'b0;
    tick();
    check("idle_pc_op", pc_op_o, 2'b01);
    check("idle_busy", busy_o, 0);
    start_i = 1'b1; mem_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("fetch0_fetch", fetch_o, 1);
    check("fetch0_pc", pc, 4'h0);
    check("fetch0_busy", busy_o, 1);
    tick();
    check("wait0_fetch", fetch_o, 0);
    check("wait0_pc_op", pc_op_o, 2'b01);
    tick();
    check("adv0_pc_op", pc_op_o, 2'b10);
    run_until_idle(adv, fc);
    check("seq_adv_count", adv, 14);
    check("seq_fetch_count", fc, 15);
    check("seq_done", done_o, 1);
    check("seq_pc_end", pc, 4'hF);
    check("seq_idle_op", pc_op_o, 2'b01);

    // 4: halt during FETCH at 5
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("rst2_done", done_o, 0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (fetch_o && pc == 4'h5) begin found = 1; break; end
      tick();
    end
    check("halt_found_fetch5", {31'd0, found}, 32'd1);
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    check("halt_wait_busy", busy_o, 1);
    check("halt_wait_op", pc_op_o, 2'b01);
    tick();
    check("halt_adv_op", pc_op_o, 2'b10);
    tick();
    check("halt_busy", busy_o, 0);
    check("halt_pc", pc, 4'h6);
    tick();
    check("halt_hold_op", pc_op_o, 2'b01);
    check("halt_hold_busy", busy_o, 0);
    check("halt_hold_pc", pc, 4'h6);
    start_i = 1'b1; halt_i = 1'b1; tick(); start_i = 1'b0; halt_i = 1'b0;
    check("resume_fetch", fetch_o, 1);
    check("resume_pc", pc, 4'h6);

    // 3: wait states, then timeout
    mem_ready_i = 1'b0; wcount = 0; found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pc_op_o == 2'b10) begin found = 1; break; end
      if (in_wait()) wcount++;
      mem_ready_i = (wcount >= 4);
    end
    check("ws_adv_seen", {31'd0, found}, 32'd1);
    check("ws_wait_count", wcount, 4);
    tick();
    check("ws_next_pc", pc, 4'h7);
    check("ws_next_fetch", fetch_o, 1);
    mem_ready_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 4'hC;
    wcount = 0; found = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!busy_o) begin found = 1; break; end
      if (in_wait()) wcount++;
    end
    jump_req_i = 1'b0;
    check("to_halted", {31'd0, found}, 32'd1);
    check("to_wait_count", wcount, 8);
    check("to_err", err_o, 1);
    check("to_pc", pc, 4'h7);
    check("to_op", pc_op_o, 2'b01);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("to_err_clr", err_o, 0);
    check("to_refetch", fetch_o, 1);
    check("to_refetch_pc", pc, 4'h7);
    mem_ready_i = 1'b1;

    // 2: jump at 8 to F, then jump at END_ADDR to 3
    found = 0;
    for (int i = 0; i < 20; i++) begin
      jump_req_i = (pc == 4'h8); jump_addr_i = 4'hF;
      tick();
      if (pc_op_o == 2'b11) begin found = 1; break; end
    end
    jump_req_i = 1'b0;
    check("jmp_seen", {31'd0, found}, 32'd1);
    check("jmp_load", pc_load_o, 4'hF);
    tick();
    check("jmp_fetch", fetch_o, 1);
    check("jmp_pc", pc, 4'hF);
    jump_req_i = 1'b1; jump_addr_i = 4'h3;
    tick();
    tick();
    jump_req_i = 1'b0;
    check("jend_op", pc_op_o, 2'b11);
    check("jend_load", pc_load_o, 4'h3);
    check("jend_done", done_o, 0);
    tick();
    check("jend_fetch_pc", pc, 4'h3);
    check("jend_load_held", pc_load_o, 4'h3);
    run_until_idle(adv, fc);
    check("jend_adv_count", adv, 12);
    check("jend_done_end", done_o, 1);

    // 5: start clears done, then reset mid-ADVANCE
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("restart_done_clr", done_o, 0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick(); tick();
    check("mr_adv_op", pc_op_o, 2'b10);
    rst = 1'b1;
    #2;
    check("mr_async_none", pc_op_o, 2'b10);
    check("mr_async_busy", busy_o, 1);
    tick();
    check("mr_clear_op", pc_op_o, 2'b00);
    check("mr_busy", busy_o, 0);
    check("mr_fetch", fetch_o, 0);
    check("mr_done", done_o, 0);
    check("mr_err", err_o, 0);
    rst = 1'b0;
    tick();
    check("mr_idle_op", pc_op_o, 2'b01);
    check("mr_pc", pc, 4'h0);

`ifdef PC_SEQ_BREAKPOINT_EN
    // 6: breakpoint at 3
    bp_en_i = 1'b1; bp_addr_i = 4'h3; mem_ready_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    fc = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fetch_o && pc == 4'h3) fc++;
      if (!busy_o) begin found = 1; break; end
    end
    check("bp_halted", {31'd0, found}, 32'd1);
    check("bp_hit", bp_hit_o, 1);
    check("bp_no_fetch3", fc, 0);
    check("bp_pc", pc, 4'h3);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("bp_resume_fetch", fetch_o, 1);
    check("bp_resume_pc", pc, 4'h3);
    check("bp_hit_clr", bp_hit_o, 0);
    tick(); tick(); tick();
    check("bp_next_fetch", fetch_o, 1);
    check("bp_next_pc", pc, 4'h4);
    bp_en_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
